ex_div_share: RTL and testbench

N-lane shared iterative divider for the multi-issue execute stage. All execute lanes share one radix-2 restoring divider; any lane may issue a divide, not only lane 0. A fixed-priority arbiter picks the lane (lane 0 is oldest in program order). The block holds the result until the owning lane's instruction leaves execute, and it aborts cleanly on an exception flush.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_iter_core.sv | 102 ++++++++++
 rtl/ex_div_share.sv | 99 +++++++++
 tb/tb_ex_div_share.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the execute-stage shared divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int DIV_XLEN = 32;

    function automatic int cntWidth(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// Radix-2 restoring divider core: magnitude iteration, bit counter and final sign fix.
module div_iter_core
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_abort,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_lastCalc,
    output logic            o_finished,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int CW = cntWidth(XLEN);
    localparam logic [CW-1:0] LAST_BIT = CW'(XLEN - 1);

    logic [CW-1:0]   r_count;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic            r_negQ;
    logic            r_negR;
    logic            r_calc;
    logic            r_fix;
    logic [XLEN-1:0] r_quotient;
    logic [XLEN-1:0] r_remainder;

    logic            w_dividendNeg;
    logic            w_divisorNeg;
    logic [XLEN-1:0] w_dividendMag;
    logic [XLEN-1:0] w_divisorMag;
    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_trial;
    logic            w_qBit;

    assign w_dividendNeg = i_signed & i_dividend[XLEN-1];
    assign w_divisorNeg  = i_signed & i_divisor[XLEN-1];
    assign w_dividendMag = w_dividendNeg ? -i_dividend : i_dividend;
    assign w_divisorMag  = w_divisorNeg  ? -i_divisor  : i_divisor;

    // Partial remainder stays below the divisor, so the top bit of r_rem is always zero
    // and the trial difference sign is unambiguous.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_shift - {2'b00, r_div};
    assign w_qBit  = ~w_trial[XLEN+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            r_calc      <= 1'b0;
            r_fix       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (i_abort) begin
            r_calc <= 1'b0;
            r_fix  <= 1'b0;
        end else if (i_start) begin
            if (i_divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= i_dividend;
            end else begin
                r_calc  <= 1'b1;
                r_count <= LAST_BIT;
                r_rem   <= '0;
                r_quo   <= w_dividendMag;
                r_div   <= w_divisorMag;
                r_negQ  <= w_dividendNeg ^ w_divisorNeg;
                r_negR  <= w_dividendNeg;
            end
        end else if (r_calc) begin
            r_rem <= w_qBit ? w_trial[XLEN:0] : w_shift[XLEN:0];
            r_quo <= {r_quo[XLEN-2:0], w_qBit};
            if (r_count == '0) begin
                r_calc <= 1'b0;
                r_fix  <= 1'b1;
            end else begin
                r_count <= r_count - CW'(1);
            end
        end else if (r_fix) begin
            r_fix       <= 1'b0;
            r_quotient  <= r_negQ ? -r_quo : r_quo;
            r_remainder <= r_negR ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        end
    end

    assign o_lastCalc  = r_calc && (r_count == '0);
    assign o_finished  = r_fix;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;

endmodule

// File: rtl/ex_div_share.sv
// Execute-stage divider shared by all lanes: fixed-priority grant, result hold until the owner leaves execute.
module ex_div_share
    import div_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = DIV_XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  excep_flush_i,
    input  logic [LANES-1:0]      req_valid_i,
    input  logic [LANES-1:0]      req_signed_i,
    input  logic [LANES*XLEN-1:0] req_dividend_i,
    input  logic [LANES*XLEN-1:0] req_divisor_i,
    input  logic [LANES-1:0]      lane_go_i,
    output logic [LANES-1:0]      grant_o,
    output logic                  busy_o,
    output logic [LANES-1:0]      done_o,
    output logic [XLEN-1:0]       quotient_o,
    output logic [XLEN-1:0]       remainder_o
);

    state_t          r_state;
    logic [LANES-1:0] r_grant;

    logic [LANES-1:0] w_pick;
    logic [XLEN-1:0]  w_dividend;
    logic [XLEN-1:0]  w_divisor;
    logic             w_signed;
    logic             w_start;
    logic             w_release;
    logic             w_lastCalc;
    logic             w_finished;

    // Lowest-index lane is oldest in program order, so it wins; operands come from the picked lane.
    always_comb begin
        w_pick     = '0;
        w_dividend = '0;
        w_divisor  = '0;
        w_signed   = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_pick    = '0;
                w_pick[i] = 1'b1;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (w_pick[i]) begin
                w_dividend = req_dividend_i[i*XLEN +: XLEN];
                w_divisor  = req_divisor_i[i*XLEN +: XLEN];
                w_signed   = req_signed_i[i];
            end
        end
    end

    assign w_start   = (r_state == IDLE) && !excep_flush_i && (req_valid_i != '0);
    assign w_release = (r_state == DONE) && ((lane_go_i & r_grant) != '0);

    div_iter_core #(.XLEN(XLEN)) u_core (
        .clk         (clk),
        .reset       (reset),
        .i_abort     (excep_flush_i),
        .i_start     (w_start),
        .i_signed    (w_signed),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_lastCalc  (w_lastCalc),
        .o_finished  (w_finished),
        .o_quotient  (quotient_o),
        .o_remainder (remainder_o)
    );

    // Flush overrides everything except reset; the DONE exit cycle never grants.
    always_ff @(posedge clk) begin
        if (reset || excep_flush_i) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_grant <= w_pick;
                    r_state <= (w_divisor == '0) ? DONE : CALC;
                end
                CALC: if (w_lastCalc) r_state <= FIX;
                FIX:  if (w_finished) r_state <= DONE;
                DONE: if (w_release) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = (r_state == DONE) ? r_grant : '0;

endmodule

// File: tb/tb_ex_div_share.sv
// Directed self-checking bench for ex_div_share with two lanes and 32-bit operands.
module tb_ex_div_share;

    localparam int LANES = 2;
    localparam int XLEN  = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  excep_flush_i;
    logic [LANES-1:0]      req_valid_i;
    logic [LANES-1:0]      req_signed_i;
    logic [LANES*XLEN-1:0] req_dividend_i;
    logic [LANES*XLEN-1:0] req_divisor_i;
    logic [LANES-1:0]      lane_go_i;
    logic [LANES-1:0]      grant_o;
    logic                  busy_o;
    logic [LANES-1:0]      done_o;
    logic [XLEN-1:0]       quotient_o;
    logic [XLEN-1:0]       remainder_o;

    int compared   = 0;
    int mismatched = 0;

    ex_div_share #(.LANES(LANES), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .excep_flush_i  (excep_flush_i),
        .req_valid_i    (req_valid_i),
        .req_signed_i   (req_signed_i),
        .req_dividend_i (req_dividend_i),
        .req_divisor_i  (req_divisor_i),
        .lane_go_i      (lane_go_i),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .quotient_o     (quotient_o),
        .remainder_o    (remainder_o)
    );

    always #5 clk = ~clk;

    // A granted lane must keep its request until it leaves execute or is flushed.
    always @(negedge clk) begin
        if (!reset && !excep_flush_i) begin
            compared++;
            if ((grant_o & ~req_valid_i & ~lane_go_i) != '0) begin
                mismatched++;
                $display("[TB] FAIL req_hold: grant %b req %b", grant_o, req_valid_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int lane, input logic sgn,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        req_signed_i[lane]               = sgn;
        req_dividend_i[lane*XLEN +: XLEN] = a;
        req_divisor_i[lane*XLEN +: XLEN]  = b;
        req_valid_i[lane]                = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        excep_flush_i  = 1'b0;
        req_valid_i    = '0;
        req_signed_i   = '0;
        req_dividend_i = '0;
        req_divisor_i  = '0;
        lane_go_i      = '0;
        repeat (2) tick();
        compared++;
        if ({grant_o, busy_o, done_o} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b want 00000", {grant_o, busy_o, done_o});
        end
        compared++;
        if ({quotient_o, remainder_o} !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h want 0", {quotient_o, remainder_o});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        applyStimulus(0, 1'b0, 32'd100, 32'd7);
        tick();
        compared++;
        if ({grant_o, busy_o} !== 3'b011) begin
            mismatched++;
            $display("[TB] FAIL unsigned_grant: got %b want 011", {grant_o, busy_o});
        end
        applyStimulus(0, 1'b0, 32'h0000FFFF, 32'd1);
        repeat (32) tick();
        compared++;
        if (done_o !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL unsigned_early: done %b want 00 at T+33", done_o);
        end
        tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'd14, 32'd2}) begin
            mismatched++;
            $display("[TB] FAIL unsigned_result: got %b %0d %0d want 01 14 2", done_o, quotient_o, remainder_o);
        end
        repeat (6) tick();
        compared++;
        if (done_o !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL unsigned_hold: done %b want 01 at T+40", done_o);
        end
        lane_go_i = 2'b01;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        compared++;
        if ({grant_o, busy_o, done_o} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL unsigned_exit: got %b want 00000", {grant_o, busy_o, done_o});
        end
    endtask

    task automatic test_signed();
        applyStimulus(1, 1'b1, 32'hFFFFFFF9, 32'd2);
        tick();
        compared++;
        if (grant_o !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL signed_grant: got %b want 10", grant_o);
        end
        repeat (33) tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b10, 32'hFFFFFFFD, 32'hFFFFFFFF}) begin
            mismatched++;
            $display("[TB] FAIL signed_result: got %b %h %h want 10 fffffffd ffffffff", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b10;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        tick();
    endtask

    task automatic test_arbitration();
        applyStimulus(0, 1'b0, 32'h10, 32'd3);
        applyStimulus(1, 1'b0, 32'd9, 32'd3);
        tick();
        compared++;
        if (grant_o !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL arb_grant0: got %b want 01", grant_o);
        end
        repeat (33) tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'd5, 32'd1}) begin
            mismatched++;
            $display("[TB] FAIL arb_lane0: got %b %0d %0d want 01 5 1", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b01;
        tick();
        req_valid_i[0] = 1'b0;
        lane_go_i      = '0;
        compared++;
        if ({grant_o, done_o} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL arb_gap: got %b want 0000", {grant_o, done_o});
        end
        tick();
        compared++;
        if (grant_o !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL arb_grant1: got %b want 10", grant_o);
        end
        repeat (33) tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b10, 32'd3, 32'd0}) begin
            mismatched++;
            $display("[TB] FAIL arb_lane1: got %b %0d %0d want 10 3 0", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b10;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        tick();
    endtask

    task automatic test_div_zero();
        applyStimulus(0, 1'b1, 32'd5, 32'd0);
        tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'hFFFFFFFF, 32'd5}) begin
            mismatched++;
            $display("[TB] FAIL divzero: got %b %h %0d want 01 ffffffff 5", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b01;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        tick();
    endtask

    task automatic test_flush();
        applyStimulus(0, 1'b0, 32'd1000, 32'd3);
        repeat (10) tick();
        excep_flush_i = 1'b1;
        tick();
        excep_flush_i = 1'b0;
        compared++;
        if ({grant_o, busy_o, done_o} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_abort: got %b want 00000", {grant_o, busy_o, done_o});
        end
        applyStimulus(0, 1'b0, 32'd8, 32'd2);
        repeat (33) tick();
        compared++;
        if (done_o !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL flush_early: done %b want 00 at T+44", done_o);
        end
        tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'd4, 32'd0}) begin
            mismatched++;
            $display("[TB] FAIL flush_result: got %b %0d %0d want 01 4 0", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b01;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        applyStimulus(1, 1'b0, 32'd6, 32'd2);
        excep_flush_i = 1'b1;
        tick();
        excep_flush_i = 1'b0;
        compared++;
        if ({grant_o, busy_o} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL flush_idle_req: got %b want 000", {grant_o, busy_o});
        end
        tick();
        compared++;
        if ({grant_o, busy_o} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL flush_then_grant: got %b want 101", {grant_o, busy_o});
        end
        excep_flush_i = 1'b1;
        tick();
        excep_flush_i = 1'b0;
        req_valid_i   = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 1'b0, 32'd20, 32'd6);
        repeat (34) tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'd3, 32'd2}) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %b %0d %0d want 01 3 2", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b01;
        tick();
        lane_go_i = '0;
        applyStimulus(0, 1'b0, 32'd21, 32'd4);
        compared++;
        if ({busy_o, done_o} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL b2b_gap: got %b want 000", {busy_o, done_o});
        end
        repeat (34) tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'd5, 32'd1}) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got %b %0d %0d want 01 5 1", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b01;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        tick();
    endtask

    task automatic test_overflow_reset();
        applyStimulus(0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        repeat (34) tick();
        compared++;
        if ({done_o, quotient_o, remainder_o} !== {2'b01, 32'h80000000, 32'd0}) begin
            mismatched++;
            $display("[TB] FAIL overflow: got %b %h %h want 01 80000000 0", done_o, quotient_o, remainder_o);
        end
        lane_go_i = 2'b01;
        tick();
        req_valid_i = '0;
        lane_go_i   = '0;
        applyStimulus(1, 1'b0, 32'd100, 32'd7);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        compared++;
        if ({grant_o, busy_o, done_o, quotient_o, remainder_o} !== 69'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_midcalc: got %b %b %b %h %h want all 0", grant_o, busy_o, done_o, quotient_o, remainder_o);
        end
        reset       = 1'b0;
        req_valid_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_arbitration();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_overflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
